// File: rtl/gecko_pkg.sv
// Shared gecko pipeline types: jump redirect command and the PC/epoch command
// passed from fetch to execute.
package gecko_pkg;

   localparam logic [31:0] PC_STEP = 32'd4;

   typedef struct packed {
      logic [31:0] jump_addr;
   } gecko_jump_command_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        epoch;
   } gecko_pc_command_t;

   // Instruction addresses are always word aligned, whatever the producer sent.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/std_mem_intf.sv
// Simple valid/ready memory request channel (request side only).
interface std_mem_intf #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                  valid;
   logic                  ready;
   logic                  read_enable;
   logic                  write_enable;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] data;

   modport out (output valid, read_enable, write_enable, addr, data, input ready);
   modport in  (input valid, read_enable, write_enable, addr, data, output ready);
endinterface

// File: rtl/std_stream_intf.sv
// Generic valid/ready stream carrying one payload of type T per transfer.
interface std_stream_intf #(
   parameter type T = logic
);
   logic valid;
   logic ready;
   T     payload;

   modport out (output valid, payload, input ready);
   modport in  (input valid, payload, output ready);
endinterface

// File: rtl/std_flow.sv
// Joins N input streams to M output streams: outputs are offered only when all
// inputs are valid, and a transfer fires only when every output is ready.
module std_flow #(
   parameter int NUM_INPUTS  = 0,
   parameter int NUM_OUTPUTS = 1
) (
   input  logic                                            enable,
   input  logic [((NUM_INPUTS > 0) ? NUM_INPUTS : 1)-1:0] input_valid,
   input  logic [NUM_OUTPUTS-1:0]                          output_ready,
   output logic [NUM_OUTPUTS-1:0]                          output_valid,
   output logic                                            fire
);
   logic inputs_valid;
   logic outputs_ready;

   // A producer with no inputs ties input_valid high.
   assign inputs_valid  = &input_valid;
   assign outputs_ready = &output_ready;
   assign output_valid  = {NUM_OUTPUTS{enable && inputs_valid}};
   assign fire          = enable && inputs_valid && outputs_ready;
endmodule

// File: rtl/std_register.sv
// Plain state register with synchronous active-low reset.
module std_register #(
   parameter int               WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] next_value,
   output logic [WIDTH-1:0] value
);
   always_ff @(posedge clk) begin
      if (!rst) value <= RESET_VALUE;
      else      value <= next_value;
   end
endmodule

// File: rtl/gecko_fetch.sv
// Gecko fetch stage: issues sequential PCs to instruction memory and execute,
// and redirects on jumps. Define GECKO_FETCH_JUMP_BYPASS_EN for zero-bubble jumps.
module gecko_fetch
   import gecko_pkg::*;
#(
   parameter logic [31:0] START_ADDR = 32'h0000_0000,
   parameter int          ADDR_WIDTH = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                jump_command_valid,
   input  gecko_jump_command_t jump_command_in,
   std_mem_intf.out            inst_request_out,
   std_stream_intf.out         pc_command_out
);

`ifdef GECKO_FETCH_JUMP_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   typedef enum logic {
      FETCH_RESET = 1'b0,
      FETCH_RUN   = 1'b1
   } fetch_state_t;

   logic              state_bits;
   fetch_state_t      state;
   fetch_state_t      state_next;
   logic [31:0]       pc;
   logic [31:0]       pc_next;
   logic              epoch;
   logic              epoch_next;
   logic              pending_valid;
   logic              pending_valid_next;
   logic [31:0]       pending_addr;
   logic [31:0]       pending_addr_next;

   logic [31:0]       jump_addr;
   logic              bypass_now;
   logic              flow_enable;
   logic [1:0]        flow_valid;
   logic              fire;
   gecko_pc_command_t issue;

   std_register #(.WIDTH(1), .RESET_VALUE(FETCH_RESET)) state_reg (
      .clk(clk), .rst(rst), .next_value(state_next), .value(state_bits)
   );
   std_register #(.WIDTH(32), .RESET_VALUE(START_ADDR)) pc_reg (
      .clk(clk), .rst(rst), .next_value(pc_next), .value(pc)
   );
   std_register #(.WIDTH(1), .RESET_VALUE(1'b0)) epoch_reg (
      .clk(clk), .rst(rst), .next_value(epoch_next), .value(epoch)
   );
   std_register #(.WIDTH(1), .RESET_VALUE(1'b0)) pending_valid_reg (
      .clk(clk), .rst(rst), .next_value(pending_valid_next), .value(pending_valid)
   );
   std_register #(.WIDTH(32), .RESET_VALUE(32'h0)) pending_addr_reg (
      .clk(clk), .rst(rst), .next_value(pending_addr_next), .value(pending_addr)
   );

   assign state       = fetch_state_t'(state_bits);
   assign jump_addr   = word_align(jump_command_in.jump_addr);
   assign bypass_now  = BYPASS && (state == FETCH_RUN) && jump_command_valid;
   // The cycle that applies a registered redirect issues nothing.
   assign flow_enable = (state == FETCH_RUN) && !pending_valid;

   std_flow #(.NUM_INPUTS(0), .NUM_OUTPUTS(2)) flow (
      .enable      (flow_enable),
      .input_valid (1'b1),
      .output_ready({pc_command_out.ready, inst_request_out.ready}),
      .output_valid(flow_valid),
      .fire        (fire)
   );

   // Issued PC/epoch: the registered values, or the jump target when bypassing.
   always_comb begin
      issue.pc    = pc;
      issue.epoch = epoch;
      if (bypass_now) begin
         issue.pc    = jump_addr;
         issue.epoch = ~epoch;
      end
   end

   assign inst_request_out.valid        = flow_valid[0];
   assign inst_request_out.read_enable  = 1'b1;
   assign inst_request_out.write_enable = 1'b0;
   assign inst_request_out.data         = '0;
   assign inst_request_out.addr         = issue.pc[ADDR_WIDTH+1:2];

   assign pc_command_out.valid   = flow_valid[1];
   assign pc_command_out.payload = issue;

   // A jump arriving with a fire lets the old PC go out; its pc+4 is dropped
   // because the pending redirect overwrites pc on the following edge.
   always_comb begin
      state_next         = state;
      pc_next            = pc;
      epoch_next         = epoch;
      pending_valid_next = pending_valid;
      pending_addr_next  = pending_addr;
      case (state)
         FETCH_RESET: state_next = FETCH_RUN;
         FETCH_RUN: begin
            if (pending_valid) begin
               pc_next            = pending_addr;
               epoch_next         = ~epoch;
               pending_valid_next = 1'b0;
            end else if (bypass_now) begin
               pc_next    = fire ? jump_addr + PC_STEP : jump_addr;
               epoch_next = ~epoch;
            end else if (fire && !jump_command_valid) begin
               pc_next = pc + PC_STEP;
            end
            if (jump_command_valid) begin
               pending_addr_next  = jump_addr;
               pending_valid_next = !BYPASS;
            end
         end
         default: state_next = FETCH_RESET;
      endcase
   end

endmodule

// File: tb/tb_gecko_fetch.sv
// Directed bench for gecko_fetch: reset, sequential fetch, stalls, jumps,
// address wrap and mid-stream reset, for either GECKO_FETCH_JUMP_BYPASS_EN build.
module tb_gecko_fetch;
   import gecko_pkg::*;

   localparam logic [31:0] START = 32'h0000_0100;

   logic                clk;
   logic                rst;
   logic                jump_command_valid;
   gecko_jump_command_t jump_command_in;
   int                  assert_count = 0;
   int                  fail_count   = 0;

   std_mem_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) inst_request ();
   std_stream_intf #(.T(gecko_pc_command_t)) pc_command ();

   gecko_fetch #(.START_ADDR(START), .ADDR_WIDTH(10)) dut (
      .clk               (clk),
      .rst               (rst),
      .jump_command_valid(jump_command_valid),
      .jump_command_in   (jump_command_in),
      .inst_request_out  (inst_request),
      .pc_command_out    (pc_command)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic jv, input logic [31:0] ja,
                                input logic ri, input logic rp);
      rst                       = r;
      jump_command_valid        = jv;
      jump_command_in.jump_addr = ja;
      inst_request.ready        = ri;
      pc_command.ready          = rp;
   endtask

   // Drive one cycle's inputs, check outputs mid-cycle, then advance a clock.
   task automatic runCycle(input string tag, input logic r, input logic jv, input logic [31:0] ja,
                           input logic ri, input logic rp, input logic exp_valid,
                           input logic show, input logic [31:0] exp_pc, input logic exp_epoch);
      applyStimulus(r, jv, ja, ri, rp);
      #1;
      checkOutput({tag, "_ivalid"}, 32'(inst_request.valid), 32'(exp_valid));
      checkOutput({tag, "_pvalid"}, 32'(pc_command.valid), 32'(exp_valid));
      if (show) begin
         checkOutput({tag, "_pc"}, pc_command.payload.pc, exp_pc);
         checkOutput({tag, "_epoch"}, 32'(pc_command.payload.epoch), 32'(exp_epoch));
         checkOutput({tag, "_addr"}, 32'(inst_request.addr), 32'(exp_pc[11:2]));
         checkOutput({tag, "_rw"}, 32'({inst_request.read_enable, inst_request.write_enable}), 32'h2);
         checkOutput({tag, "_wdata"}, inst_request.data, 32'h0);
      end
      @(negedge clk);
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      @(negedge clk);
      //        tag    rst jv  jump_addr     ri rp  valid show pc            epoch
      runCycle("r1",  0,  1,  32'h0000_5000, 1, 1,  0,    1,   START,         0);
      runCycle("c1",  1,  1,  32'h0000_6000, 1, 1,  0,    1,   START,         0);
      runCycle("c2",  1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_0100, 0);
      runCycle("c3",  1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_0104, 0);
      runCycle("c4",  1,  0,  32'h0,         1, 0,  1,    1,   32'h0000_0108, 0);
      runCycle("c5",  1,  0,  32'h0,         1, 0,  1,    1,   32'h0000_0108, 0);
      runCycle("c6",  1,  0,  32'h0,         1, 0,  1,    1,   32'h0000_0108, 0);
      runCycle("c7",  1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_0108, 0);
`ifdef GECKO_FETCH_JUMP_BYPASS_EN
      runCycle("c8",  1,  1,  32'h0000_2001, 1, 1,  1,    1,   32'h0000_2000, 1);
      runCycle("c9",  1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_2004, 1);
      runCycle("c10", 1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_2008, 1);
      runCycle("c11", 1,  1,  32'h0000_3000, 1, 0,  1,    1,   32'h0000_3000, 0);
      runCycle("c12", 1,  1,  32'h0000_4000, 1, 0,  1,    1,   32'h0000_4000, 1);
      runCycle("c13", 1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_4000, 1);
      runCycle("c14", 1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_4004, 1);
      runCycle("c15", 1,  1,  32'hFFFF_FFF8, 1, 0,  1,    1,   32'hFFFF_FFF8, 0);
      runCycle("c16", 1,  0,  32'h0,         1, 1,  1,    1,   32'hFFFF_FFF8, 0);
      runCycle("c17", 1,  0,  32'h0,         1, 1,  1,    1,   32'hFFFF_FFFC, 0);
      runCycle("c18", 1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_0000, 0);
      runCycle("c19", 1,  0,  32'h0,         0, 1,  1,    1,   32'h0000_0004, 0);
      runCycle("c20", 1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_0004, 0);
      runCycle("c21", 0,  0,  32'h0,         1, 1,  1,    1,   32'h0000_0008, 0);
`else
      runCycle("c8",  1,  1,  32'h0000_2001, 1, 1,  1,    1,   32'h0000_010C, 0);
      runCycle("c9",  1,  0,  32'h0,         1, 1,  0,    0,   32'h0,         0);
      runCycle("c10", 1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_2000, 1);
      runCycle("c11", 1,  1,  32'h0000_3000, 1, 0,  1,    1,   32'h0000_2004, 1);
      runCycle("c12", 1,  1,  32'h0000_4000, 1, 0,  0,    0,   32'h0,         0);
      runCycle("c13", 1,  0,  32'h0,         1, 1,  0,    0,   32'h0,         0);
      runCycle("c14", 1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_4000, 1);
      runCycle("c15", 1,  1,  32'hFFFF_FFF8, 1, 0,  1,    1,   32'h0000_4004, 1);
      runCycle("c16", 1,  0,  32'h0,         1, 1,  0,    0,   32'h0,         0);
      runCycle("c17", 1,  0,  32'h0,         1, 1,  1,    1,   32'hFFFF_FFF8, 0);
      runCycle("c18", 1,  0,  32'h0,         1, 1,  1,    1,   32'hFFFF_FFFC, 0);
      runCycle("c19", 1,  0,  32'h0,         0, 1,  1,    1,   32'h0000_0000, 0);
      runCycle("c20", 1,  0,  32'h0,         1, 1,  1,    1,   32'h0000_0000, 0);
      runCycle("c21", 0,  0,  32'h0,         1, 1,  1,    1,   32'h0000_0004, 0);
`endif
      runCycle("c22", 1,  0,  32'h0,         1, 1,  0,    1,   START,         0);
      runCycle("c23", 1,  0,  32'h0,         1, 1,  1,    1,   START,         0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
